// File: rtl/contador_cascada_pkg.sv
// Shared helpers for the counter family: bit-width calculation, stage width
// and terminal value derivation from a count modulus.
package contador_cascada_pkg;

  // Number of bits needed to encode values 0 .. value-1 (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value - 1;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

  // Width of one stage counting modulo 'modulo'; at least one bit.
  function automatic int stage_width(input int modulo);
    int w;
    w = clogb2(modulo);
    return (w < 1) ? 1 : w;
  endfunction

  // Terminal value of a stage: top of range when counting up, zero when down.
  function automatic int terminal_value(input int modulo, input logic up);
    return up ? (modulo - 1) : 0;
  endfunction

endpackage

// File: rtl/contador_etapa.sv
// One modulo-MODULO up/down stage with synchronous clear, clamped parallel
// load and a combinational terminal flag for the current direction.
module contador_etapa
  import contador_cascada_pkg::*;
#(
  parameter  int MODULO = 10,
  localparam int W      = stage_width(MODULO)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         paso,
  input  logic         up_down,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] dato,
  output logic [W-1:0] valor,
  output logic         fin_etapa
);

  localparam logic [W-1:0] MAX_VAL = W'(terminal_value(MODULO, 1'b1));
  localparam logic [W-1:0] MIN_VAL = W'(terminal_value(MODULO, 1'b0));

  logic [W-1:0] r_valor;
  logic [W-1:0] w_siguiente;

  // Terminal flag follows up_down immediately, no register in between.
  always_comb begin
    fin_etapa = up_down ? (r_valor == MAX_VAL) : (r_valor == MIN_VAL);
  end

  // Next value: clear beats load beats step beats hold; load saturates at MAX_VAL
  // so codes above MODULO-1 can never enter the register.
  always_comb begin
    w_siguiente = r_valor;
    if (clear) begin
      w_siguiente = '0;
    end else if (load) begin
      w_siguiente = (dato > MAX_VAL) ? MAX_VAL : dato;
    end else if (paso) begin
      if (up_down) begin
        w_siguiente = (r_valor == MAX_VAL) ? '0 : (r_valor + W'(1));
      end else begin
        w_siguiente = (r_valor == '0) ? MAX_VAL : (r_valor - W'(1));
      end
    end
  end

  // Stage register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valor <= '0;
    end else begin
      r_valor <= w_siguiente;
    end
  end

  assign valor = r_valor;

endmodule

// File: rtl/contador_cascada.sv
// Chain of NUM_ETAPAS modulo-MODULO up/down stages. A stage steps when enable
// is high and every lower stage is at its terminal value (same-cycle ripple).
module contador_cascada
  import contador_cascada_pkg::*;
#(
  parameter  int MODULO     = 10,
  parameter  int NUM_ETAPAS = 4,
  localparam int W          = stage_width(MODULO)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [NUM_ETAPAS*W-1:0] dato_carga,
  output logic [NUM_ETAPAS*W-1:0] cuenta,
  output logic [NUM_ETAPAS-1:0] fin_etapa,
  output logic                  fin_cuenta,
  output logic                  acarreo
);

  // w_paso[i] is the step request of stage i: enable ANDed with all lower flags.
  logic [NUM_ETAPAS-1:0] w_paso;
  logic [NUM_ETAPAS-1:0] w_fin;

  assign w_paso[0] = enable;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ETAPAS; gi++) begin : g_etapa
      if (gi > 0) begin : g_carry
        assign w_paso[gi] = w_paso[gi-1] & w_fin[gi-1];
      end

      contador_etapa #(
        .MODULO (MODULO)
      ) u_etapa (
        .clock     (clock),
        .reset     (reset),
        .paso      (w_paso[gi]),
        .up_down   (up_down),
        .clear     (clear),
        .load      (load),
        .dato      (dato_carga[gi*W +: W]),
        .valor     (cuenta[gi*W +: W]),
        .fin_etapa (w_fin[gi])
      );
    end
  endgenerate

  // Whole-chain terminal detect; acarreo lets a following block cascade.
  always_comb begin
    fin_etapa  = w_fin;
    fin_cuenta = &w_fin;
    acarreo    = fin_cuenta & enable;
  end

endmodule
